// File: rtl/fp_div_pkg.sv
// Shared types and sizing helpers for the sequential mantissa divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Quotient width: two integer/guard bits plus mant_w fraction bits.
    function automatic int qw(input int mant_w);
        return mant_w + 2;
    endfunction

    // Counter width able to hold 0..qw(mant_w).
    function automatic int cnt_w(input int mant_w);
        return $clog2(qw(mant_w) + 1);
    endfunction

    // Count width for the default single-precision mantissa.
    localparam int CNT_W = cnt_w(24);

endpackage

// File: rtl/seq_mant_div_step.sv
// One radix-2 restoring division step: shift in a bit, subtract divisor if it fits.
// Latency: purely combinational.
// Backpressure: none, evaluated every cycle by the owning FSM.
module div_step #(
    parameter int MANT_W = 24
) (
    input  logic [MANT_W:0]   rem_in,
    input  logic              next_bit,
    input  logic [MANT_W-1:0] divisor,
    output logic [MANT_W:0]   rem_out,
    output logic              q_bit
);

    logic [MANT_W:0] shifted;
    logic [MANT_W:0] diff;

    // The bit shifted out of the top is always zero while rem < divisor; it is
    // still folded into the compare so the step stays correct modulo 2^(MANT_W+1).
    assign shifted = {rem_in[MANT_W-1:0], next_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = rem_in[MANT_W] | (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/seq_mant_div.sv
// Iterative restoring mantissa divider, one quotient bit per clock, with sticky and divide-by-zero flags.
// Latency: qw(MANT_W) edges from acceptance to out_valid (1 edge for a zero divisor).
// Backpressure: result held in DONE until out_ready; in_ready low for the whole operation.
module seq_mant_div
    import fp_div_pkg::*;
#(
    parameter int MANT_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MANT_W-1:0]       dividend,
    input  logic [MANT_W-1:0]       divisor,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [qw(MANT_W)-1:0]   quot,
    output logic                    sticky,
    output logic                    dbz
);

    localparam int QW = qw(MANT_W);
    localparam int CW = cnt_w(MANT_W);

    state_t            state;
    logic [MANT_W-1:0] dvsr_q;
    logic              dvd_lsb_q;
    logic [MANT_W:0]   rem_q;
    logic [CW-1:0]     cnt_q;

    logic [MANT_W:0]   rem_nxt;
    logic              q_bit;
    logic              nbit;

    // The leading MANT_W-1 quotient bits are zero for a normalised divisor, so
    // the remainder is preloaded with dividend[MANT_W-1:1]; the QW steps then
    // consume dividend[0] followed by MANT_W+1 zeros.
    assign nbit = (cnt_q == '0) ? dvd_lsb_q : 1'b0;

    div_step #(
        .MANT_W (MANT_W)
    ) u_step (
        .rem_in   (rem_q),
        .next_bit (nbit),
        .divisor  (dvsr_q),
        .rem_out  (rem_nxt),
        .q_bit    (q_bit)
    );

    // Control FSM, operand/remainder/quotient registers and registered handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quot      <= '0;
            sticky    <= 1'b0;
            dbz       <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvsr_q    <= '0;
            dvd_lsb_q <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvsr_q    <= divisor;
                        dvd_lsb_q <= dividend[0];
                        rem_q     <= {2'b00, dividend[MANT_W-1:1]};
                        cnt_q     <= '0;
                        in_ready  <= 1'b0;
                        sticky    <= 1'b0;
                        if (divisor == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            quot      <= '1;
                            dbz       <= 1'b1;
                        end else begin
                            state     <= RUN;
                            quot      <= '0;
                            dbz       <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_nxt;
                    quot  <= {quot[QW-2:0], q_bit};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(QW - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        sticky    <= |rem_nxt;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mant_div.sv
// Self-checking bench for seq_mant_div at MANT_W=24 and MANT_W=11.
// Latency: n/a.
// Backpressure: exercised through directed out_ready holds and random stalls.
module tb_seq_mant_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] dividend = '0;
    logic [23:0] divisor = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, sticky_a, dbz_a;
    logic [25:0] quot_a;
    logic        in_ready_b, out_valid_b, sticky_b, dbz_b;
    logic [12:0] quot_b;

    logic        in_ready_m, out_valid_m, sticky_m, dbz_m;
    logic [25:0] quot_m;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_mant_div #(.MANT_W(24)) u_dut24 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid && !sel),
        .in_ready  (in_ready_a),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .out_valid (out_valid_a),
        .out_ready (out_ready && !sel),
        .quot      (quot_a),
        .sticky    (sticky_a),
        .dbz       (dbz_a)
    );

    seq_mant_div #(.MANT_W(11)) u_dut11 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid && sel),
        .in_ready  (in_ready_b),
        .dividend  (dividend[10:0]),
        .divisor   (divisor[10:0]),
        .flush     (flush),
        .out_valid (out_valid_b),
        .out_ready (out_ready && sel),
        .quot      (quot_b),
        .sticky    (sticky_b),
        .dbz       (dbz_b)
    );

    assign in_ready_m  = sel ? in_ready_b  : in_ready_a;
    assign out_valid_m = sel ? out_valid_b : out_valid_a;
    assign sticky_m    = sel ? sticky_b    : sticky_a;
    assign dbz_m       = sel ? dbz_b       : dbz_a;
    assign quot_m      = sel ? {13'd0, quot_b} : quot_a;

    // in_ready and out_valid must never be high together on either instance.
    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(in_ready_a && out_valid_a) && !(in_ready_b && out_valid_b))
            else begin
                n_err++;
                $error("FAIL rdy_vld_excl observed a=%b%b b=%b%b expected not both high",
                       in_ready_a, out_valid_a, in_ready_b, out_valid_b);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: quotient of the dividend scaled by 2^(mw+1), plus remainder test.
    function automatic void ref_div(input int mw, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] q, output logic s, output logic d);
        if (b == 64'd0) begin
            q = (64'd1 << (mw + 2)) - 64'd1;
            s = 1'b0;
            d = 1'b1;
        end else begin
            q = (a << (mw + 1)) / b;
            s = ((a << (mw + 1)) % b) != 64'd0;
            d = 1'b0;
        end
    endfunction

    task automatic start_op(input logic [23:0] a, input logic [23:0] b);
        int t;
        t = 0;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        while (!in_ready_m && t < 100) begin
            step();
            t++;
        end
        chk("accept_wait", 64'(in_ready_m), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!out_valid_m && lat < 200);
    endtask

    task automatic finish_op(input logic [23:0] a, input logic [23:0] b, input int stall);
        int          lat;
        int          mw;
        logic [63:0] eq;
        logic        es, ed;
        mw = sel ? 11 : 24;
        ref_div(mw, 64'(a), 64'(b), eq, es, ed);
        wait_done(lat);
        chk("latency", 64'(lat), ed ? 64'd1 : 64'(mw + 2));
        repeat (stall) step();
        chk("out_valid", 64'(out_valid_m), 64'd1);
        chk("quot", 64'(quot_m), eq);
        chk("sticky", 64'(sticky_m), 64'(es));
        chk("dbz", 64'(dbz_m), 64'(ed));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_hs_out_valid", 64'(out_valid_m), 64'd0);
        chk("post_hs_in_ready", 64'(in_ready_m), 64'd1);
    endtask

    task automatic do_op(input logic [23:0] a, input logic [23:0] b, input int stall);
        start_op(a, b);
        finish_op(a, b, stall);
    endtask

    initial begin
        logic [23:0] ra, rb;
        int          mw;

        // Reset state
        #12;
        chk("rst_in_ready", 64'(in_ready_a), 64'd1);
        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_quot", 64'(quot_a), 64'd0);
        chk("rst_sticky", 64'(sticky_a), 64'd0);
        chk("rst_dbz", 64'(dbz_a), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Directed single-precision cases
        do_op(24'hFE1000, 24'h878000, 0);
        do_op(24'h800000, 24'h800000, 1);
        do_op(24'h800000, 24'hC00000, 2);
        do_op(24'hABCDEF, 24'h000000, 0);

        // Backpressure: hold result 10 cycles while a new operand waits
        start_op(24'h800000, 24'hC00000);
        begin
            int lat;
            wait_done(lat);
            chk("bp_latency", 64'(lat), 64'd26);
        end
        dividend = 24'hFE1000;
        divisor  = 24'h878000;
        in_valid = 1'b1;
        repeat (10) begin
            step();
            chk("bp_out_valid", 64'(out_valid_m), 64'd1);
            chk("bp_in_ready", 64'(in_ready_m), 64'd0);
            chk("bp_quot", 64'(quot_m), 64'h1555555);
            chk("bp_sticky", 64'(sticky_m), 64'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_rel_out_valid", 64'(out_valid_m), 64'd0);
        chk("bp_rel_in_ready", 64'(in_ready_m), 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_next_accepted", 64'(in_ready_m), 64'd0);
        finish_op(24'hFE1000, 24'h878000, 0);

        // Reset asserted mid-run
        start_op(24'hFE1000, 24'h878000);
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready_a), 64'd1);
        chk("arst_out_valid", 64'(out_valid_a), 64'd0);
        chk("arst_quot", 64'(quot_a), 64'd0);
        chk("arst_sticky", 64'(sticky_a), 64'd0);
        chk("arst_dbz", 64'(dbz_a), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        do_op(24'h800000, 24'hC00000, 0);

        // Flush mid-run
        start_op(24'hFE1000, 24'h878000);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_out_valid", 64'(out_valid_m), 64'd0);
        chk("flush_in_ready", 64'(in_ready_m), 64'd1);
        repeat (30) step();
        chk("flush_no_result", 64'(out_valid_m), 64'd0);
        do_op(24'hFE1000, 24'h878000, 0);

        // Random normalised pairs for both widths with random stalls
        for (int w = 0; w < 2; w++) begin
            sel = (w == 1);
            mw  = sel ? 11 : 24;
            step();
            for (int i = 0; i < 1000; i++) begin
                ra = 24'(($urandom & ((32'd1 << (mw - 1)) - 1)) | (32'd1 << (mw - 1)));
                rb = 24'(($urandom & ((32'd1 << (mw - 1)) - 1)) | (32'd1 << (mw - 1)));
                if (i % 4 == 0) rb = ra;
                do_op(ra, rb, int'($urandom_range(0, 3)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_mant_div.md
# seq_mant_div

Parametrised, iterative radix-2 restoring divider for floating-point mantissas, producing one quotient bit per clock with a sticky bit for rounding. It is the sequential successor to the single-cycle 24-bit mantissa divider in the FP division path. It sits between exponent/sign handling and the rounding/normalisation stage. Mantissa width is generic, so the same block serves single precision (24) and other formats. Valid/ready handshakes on both sides give backpressure.

## Interface
- MANT_W, 24, mantissa width including hidden bit
- QW (derived, not overridable), MANT_W+2, quotient width: 2 integer/guard bits plus MANT_W fraction bits
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- dividend  in  MANT_W  normalised mantissa (MSB=1 expected, not checked)
- divisor  in  MANT_W  normalised mantissa; zero flagged
- flush  in  1  synchronous abort, returns block to IDLE
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- quot  out  QW  floor((dividend << (MANT_W+1)) / divisor)
- sticky  out  1  remainder != 0
- dbz  out  1  divisor was zero

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid:
  - Latch operands and clear the count, partial remainder and quotient register.
  - If divisor==0, go to DONE with quot=all ones, sticky=0, dbz=1.
  - Otherwise go to RUN with dbz=0.
- RUN, one step per cycle:
  - rem = (rem<<1) | next dividend bit, where the extended dividend is dividend followed by MANT_W+1 zeros.
  - If rem >= divisor: rem -= divisor and shift in 1; otherwise shift in 0.
  - Remainder register width is MANT_W+1. No overflow is possible.
  - After QW steps go to DONE. sticky = (final rem != 0).
- DONE: out_valid=1. quot, sticky and dbz are held stable until out_ready. On the handshake cycle go to IDLE.
- flush: sampled in any state. It overrides everything else and forces IDLE next cycle with out_valid=0. Datapath registers are don't-care.
- Operand inputs are ignored when in_ready=0. Only one operation is in flight at a time.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, quot=0, sticky=0, dbz=0, count=0.
- Reset asserted mid-operation aborts immediately. No result is emitted.
- Normal latency: out_valid rises QW clock edges after the acceptance edge (26 for MANT_W=24).
- Divide-by-zero latency: out_valid rises 1 edge after acceptance.
- in_ready returns 1 on the cycle after the output handshake. Throughput is one operation per QW+2 cycles minimum.
- Handshake completes on a rising edge with valid&&ready both high.
- in_ready and out_valid are never high together.
- in_ready and out_valid are registered state decodes. They have no combinational path from in_valid or out_ready.
- flush and out_ready asserted together in DONE: flush wins, but the result counts as not consumed.

## Structure
- Package fp_div_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the function qw(mant_w) returning mant_w+2;
  - the localparam for the count width, $clog2(QW+1).
- One natural sub-module, div_step: combinational single restoring step.
  - Inputs: rem_in, next bit, divisor.
  - Outputs: rem_out, q_bit.
  - Parametrised by MANT_W.
- The top level holds the FSM, counter, operand/remainder/quotient registers and handshakes.

## Test plan
- Exact result: dividend=0xFE1000, divisor=0x878000 (MANT_W=24) → quot=0x3C00000, sticky=0, dbz=0, out_valid after exactly 26 edges.
- Unity: dividend=divisor=0x800000 → quot=0x2000000, sticky=0.
- Inexact: dividend=0x800000, divisor=0xC00000 → quot=0x1555555, sticky=1.
- Divide by zero: divisor=0 → dbz=1, quot=0x3FFFFFF, sticky=0, out_valid one edge after acceptance.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0, no new acceptance while in_valid is held high. Then release → IDLE and the next operand is accepted.
- Abort:
  - Assert rst_n=0 at step 10 of RUN → all outputs at reset values immediately.
  - Separately, pulse flush at step 5 → IDLE next cycle, no out_valid.
  - Both cases: the following operation returns the correct result.
- Random: 1000 random normalised operand pairs for MANT_W=24 and MANT_W=11, checked against a reference model, with random out_ready stalls.
